// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBUS definitions: request/response structs, burst and length encodings,
// plus the wrap-window helper used by burst responders.
package cbus_sram_responder_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } cbus_burst_e;

  // Beat count of a burst is len + 1 (1..16 beats).
  typedef logic [3:0] cbus_len_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    cbus_len_t              len;
    cbus_burst_e            burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  // Word-offset mask of a wrap window; exact for 1/2/4/8/16-beat bursts,
  // other lengths wrap within the next larger power-of-two window.
  function automatic cbus_len_t wrap_mask(input cbus_len_t len);
    return len | (len >> 1) | (len >> 2) | (len >> 3);
  endfunction

endpackage

// File: rtl/cbus_sram_array.sv
// Word-organised SRAM with one synchronous-write, combinational-read port and
// per-byte write enables; each byte lane is its own storage array.
module cbus_sram_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane [WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane[addr];
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// CBUS burst target backed by a local SRAM; accepts one request at a time and
// answers each beat with a single ready pulse, optionally preceded by wait cycles.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int WAIT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [1:0]        S_AFTER   = (WAIT_CYCLES > 0) ? S_WAIT : S_BEAT;

  logic [1:0]        state_reg;
  logic [31:0]       addr_reg;
  logic              is_write_reg;
  cbus_len_t         len_reg;
  cbus_burst_e       burst_reg;
  cbus_len_t         beat_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic [AW-1:0] word_idx;
  logic          final_beat;
  logic          mem_we;
  logic [63:0]   mem_rdata;
  logic [28:0]   word_addr;
  logic [28:0]   word_next;
  logic [28:0]   win_mask;
  logic [2:0]    unused_size;

  assign word_idx    = addr_reg[3 +: AW];
  assign final_beat  = (beat_cnt_reg == len_reg);
  assign mem_we      = (state_reg == S_BEAT) && is_write_reg;
  assign word_addr   = addr_reg[31:3];
  assign win_mask    = {25'd0, wrap_mask(len_reg)};
  assign unused_size = creq.size;

  always_comb begin
    word_next = word_addr;
    case (burst_reg)
      BURST_INCR: word_next = word_addr + 29'd1;
      // Only the offset bits inside the aligned window advance; the base stays put.
      BURST_WRAP: word_next = (word_addr & ~win_mask) | ((word_addr + 29'd1) & win_mask);
      default:    word_next = word_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      is_write_reg <= 1'b0;
      len_reg      <= '0;
      burst_reg    <= BURST_FIXED;
      beat_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (creq.valid) begin
            addr_reg     <= creq.addr;
            is_write_reg <= creq.is_write;
            len_reg      <= creq.len;
            burst_reg    <= creq.burst;
            beat_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            state_reg    <= S_AFTER;
          end
        end
        S_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= '0;
            state_reg    <= S_BEAT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        S_BEAT: begin
          if (final_beat) begin
            state_reg <= S_DONE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            addr_reg     <= {word_next, addr_reg[2:0]};
            state_reg    <= S_AFTER;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  cbus_sram_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (creq.strobe),
    .addr  (word_idx),
    .wdata (creq.data),
    .rdata (mem_rdata)
  );

  // Response depends only on registered state and stored data.
  always_comb begin
    cresp = '0;
    if (state_reg == S_BEAT) begin
      cresp.ready = 1'b1;
      cresp.last  = final_beat;
      cresp.data  = is_write_reg ? 64'd0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: directed scenarios plus random bursts on a
// zero-wait and a two-wait instance, checked against a word-array model.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int WORDS = 64;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  cbus_req_t  creq0, creq2;
  cbus_resp_t cresp0, cresp2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [63:0] model [2][WORDS];
  logic [63:0] bd [16];
  logic [7:0]  bs [16];

  always #5 clk = ~clk;

  cbus_sram_responder #(.MEM_WORDS(WORDS), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .creq(creq0), .cresp(cresp0));
  cbus_sram_responder #(.MEM_WORDS(WORDS), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst2), .creq(creq2), .cresp(cresp2));

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, want finish");
    $fatal(1, "timeout");
  end

  function automatic cbus_resp_t get_resp(input int sel);
    return (sel == 0) ? cresp0 : cresp2;
  endfunction

  task automatic drive_req(input int sel, input cbus_req_t r);
    if (sel == 0) creq0 = r;
    else          creq2 = r;
  endtask

  // Word visited by beat i, from the burst rules stated in byte/word arithmetic.
  function automatic int model_idx(input logic [31:0] addr, input logic [3:0] len,
                                   input cbus_burst_e b, input int i);
    int s, n;
    s = int'(addr >> 3);
    n = int'(len) + 1;
    case (b)
      BURST_INCR: return (s + i) % WORDS;
      BURST_WRAP: return ((s - (s % n)) + ((s % n) + i) % n) % WORDS;
      default:    return s % WORDS;
    endcase
  endfunction

  task automatic run_txn(input int sel, input logic wr, input logic [31:0] addr,
                         input logic [3:0] len, input cbus_burst_e burst,
                         input string tag, input bit poke_done);
    int w, m, beats, beat, k, idx;
    bit exp_ready;
    cbus_req_t  r;
    cbus_resp_t rs;
    logic [63:0] exp_data;
    w = (sel == 0) ? 0 : 2;
    m = (sel == 0) ? 0 : 1;
    beats = int'(len) + 1;
    r.valid = 1'b1; r.is_write = wr; r.size = 3'($urandom); r.addr = addr;
    r.strobe = 8'($urandom); r.data = {$urandom, $urandom}; r.len = len; r.burst = burst;
    drive_req(sel, r);
    @(posedge clk); #1;
    // Everything except per-beat data/strobe must now be ignored.
    r.valid = 1'b0; r.is_write = ~wr; r.addr = $urandom; r.len = 4'($urandom);
    drive_req(sel, r);
    beat = 0;
    k = 1;
    while (beat < beats) begin
      rs = get_resp(sel);
      exp_ready = ((k % (w + 1)) == 0);
      chk_cnt++;
      if (rs.ready !== exp_ready) $display("FAIL %s ready: got %0b want %0b (beat %0d cycle %0d)", tag, rs.ready, exp_ready, beat, k);
      else pass_cnt++;
      if (exp_ready) begin
        idx = model_idx(addr, len, burst, beat);
        if (wr) begin
          exp_data = 64'd0;
          r.data = bd[beat]; r.strobe = bs[beat];
          drive_req(sel, r);
          for (int b = 0; b < 8; b++)
            if (bs[beat][b]) model[m][idx][b*8 +: 8] = bd[beat][b*8 +: 8];
        end else begin
          exp_data = model[m][idx];
        end
        chk_cnt++;
        if (rs.last !== (beat == beats - 1)) $display("FAIL %s last: got %0b want %0b (beat %0d)", tag, rs.last, (beat == beats - 1), beat);
        else pass_cnt++;
        chk_cnt++;
        if (rs.data !== exp_data) $display("FAIL %s data: got %h want %h (beat %0d word %0d)", tag, rs.data, exp_data, beat, idx);
        else pass_cnt++;
        beat++;
      end
      @(posedge clk); #1;
      k++;
    end
    rs = get_resp(sel);
    chk_cnt++;
    if (rs !== '0) $display("FAIL %s done_idle: got %h want 0", tag, rs);
    else pass_cnt++;
    if (poke_done) begin
      r.valid = 1'b1; r.is_write = 1'b0; r.len = 4'd0; r.burst = BURST_INCR;
      drive_req(sel, r);
    end
    @(posedge clk); #1;
    if (poke_done) begin
      r.valid = 1'b0;
      drive_req(sel, r);
      for (int c = 0; c < 4; c++) begin
        rs = get_resp(sel);
        chk_cnt++;
        if (rs.ready !== 1'b0) $display("FAIL %s done_ignored: got ready %0b want 0 (cycle %0d)", tag, rs.ready, c);
        else pass_cnt++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    creq0 = '0; creq2 = '0;
    rst0 = 1'b0; rst2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (cresp0 !== '0) $display("FAIL reset_resp0: got %h want 0", cresp0); else pass_cnt++;
    chk_cnt++;
    if (cresp2 !== '0) $display("FAIL reset_resp2: got %h want 0", cresp2); else pass_cnt++;
    rst0 = 1'b1; rst2 = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (cresp0 !== '0) $display("FAIL post_reset_idle: got %h want 0", cresp0); else pass_cnt++;
  endtask

  task automatic test_fill;
    for (int s = 0; s < 2; s++)
      for (int blk = 0; blk < WORDS / 16; blk++) begin
        for (int i = 0; i < 16; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'hFF; end
        run_txn(s, 1'b1, 32'(blk * 128), 4'd15, BURST_INCR, "fill", 1'b0);
      end
  endtask

  task automatic test_single_read;
    bd[0] = 64'h1122334455667788; bs[0] = 8'hFF;
    run_txn(0, 1'b1, 32'h10, 4'd0, BURST_INCR, "single_wr", 1'b0);
    run_txn(0, 1'b0, 32'h10, 4'd0, BURST_INCR, "single_rd", 1'b0);
  endtask

  task automatic test_incr_burst;
    for (int i = 0; i < 4; i++) begin bd[i] = 64'(8'hA0 + i); bs[i] = 8'hFF; end
    run_txn(0, 1'b1, 32'h40, 4'd3, BURST_INCR, "incr_wr", 1'b0);
    run_txn(0, 1'b0, 32'h40, 4'd3, BURST_INCR, "incr_rd", 1'b0);
  endtask

  task automatic test_partial_strobe;
    bd[0] = 64'd0; bs[0] = 8'hFF;
    run_txn(0, 1'b1, 32'h0, 4'd0, BURST_FIXED, "strb_clr", 1'b0);
    bd[0] = 64'hFFFF_FFFF_FFFF_FFFF; bs[0] = 8'h0F;
    run_txn(0, 1'b1, 32'h0, 4'd0, BURST_FIXED, "strb_wr", 1'b0);
    run_txn(0, 1'b0, 32'h0, 4'd0, BURST_FIXED, "strb_rd", 1'b0);
  endtask

  task automatic test_wrap_read;
    run_txn(0, 1'b0, 32'h18, 4'd3, BURST_WRAP, "wrap_rd", 1'b0);
    run_txn(1, 1'b0, 32'h38, 4'd7, BURST_WRAP, "wrap_rd_w2", 1'b0);
  endtask

  task automatic test_wait_cycles;
    run_txn(1, 1'b0, 32'h20, 4'd1, BURST_INCR, "wait_rd", 1'b0);
    for (int i = 0; i < 3; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'($urandom); end
    run_txn(1, 1'b1, 32'h1F8, 4'd2, BURST_INCR, "wait_wr_wrapmem", 1'b0);
    run_txn(1, 1'b0, 32'h1F8, 4'd2, BURST_INCR, "wait_rd_wrapmem", 1'b0);
  endtask

  task automatic test_done_ignored;
    run_txn(0, 1'b0, 32'h8, 4'd1, BURST_INCR, "done_poke0", 1'b1);
    run_txn(1, 1'b0, 32'h8, 4'd0, BURST_FIXED, "done_poke2", 1'b1);
  endtask

  task automatic test_reset_mid_burst;
    cbus_req_t r;
    for (int i = 0; i < 4; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'hFF; end
    r = '0;
    r.valid = 1'b1; r.is_write = 1'b1; r.addr = 32'h0; r.len = 4'd3; r.burst = BURST_INCR;
    creq0 = r;
    @(posedge clk); #1;
    r.valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      r.data = bd[b]; r.strobe = bs[b];
      creq0 = r;
      chk_cnt++;
      if (cresp0.ready !== 1'b1) $display("FAIL rst_mid ready: got %0b want 1 (beat %0d)", cresp0.ready, b);
      else pass_cnt++;
      if (b < 2) begin
        model[0][b] = bd[b];
        @(posedge clk); #1;
      end
    end
    #2;
    rst0 = 1'b0;
    #1;
    chk_cnt++;
    if (cresp0 !== '0) $display("FAIL rst_mid_async: got %h want 0", cresp0); else pass_cnt++;
    @(posedge clk); #1;
    creq0 = '0;
    rst0 = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (cresp0 !== '0) $display("FAIL rst_mid_idle: got %h want 0", cresp0); else pass_cnt++;
    run_txn(0, 1'b0, 32'h0, 4'd3, BURST_INCR, "rst_mid_rd", 1'b0);
  endtask

  task automatic test_random;
    int sel;
    logic wr;
    logic [3:0] len;
    cbus_burst_e b;
    int wrap_lens [5] = '{0, 1, 3, 7, 15};
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      wr  = 1'($urandom);
      b   = cbus_burst_e'(2'($urandom_range(0, 2)));
      len = (b == BURST_WRAP) ? 4'(wrap_lens[$urandom_range(0, 4)]) : 4'($urandom);
      for (int i = 0; i < 16; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'($urandom); end
      run_txn(sel, wr, $urandom, len, b, "random", 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_read();
    test_incr_burst();
    test_partial_strobe();
    test_wrap_read();
    test_wait_cycles();
    test_done_ignored();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
